prog_mem: RTL and testbench
===========================

PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, the memory address width (16 words).
REQ-002 The block SHALL have parameter DATA_W, default 8, the memory word width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port mem_address  input  ADDR_W  CPU word address.
REQ-006 The block SHALL have port mem_data_r  output  DATA_W  read data to the CPU.
REQ-007 The block SHALL have port mem_data_w  input  DATA_W  write data from the CPU.
REQ-008 The block SHALL have port mem_we  input  1  CPU write enable.
REQ-009 The block SHALL have port cpu_reset_n  output  1  registered active-low CPU reset.
REQ-010 The block SHALL have port ld_start  input  1  one-cycle request to start a program load.
REQ-011 The block SHALL have ports ld_valid (input, 1), ld_data (input, DATA_W) and ld_ready (output, 1) forming the load byte stream.
REQ-012 The block SHALL have port dump_start  input  1  one-cycle request to start a memory dump.
REQ-013 The block SHALL have ports dp_valid (output, 1), dp_addr (output, ADDR_W), dp_data (output, DATA_W) and dp_ready (input, 1) forming the dump stream.
REQ-014 The block SHALL have port busy  output  1  high in any state other than RUN.

Function
REQ-015 mem_data_r SHALL be a combinational read of mem[mem_address], valid in the same cycle the address is presented; this zero-latency read matches the CPU sampling data one cycle after it registers the address.
REQ-016 In RUN, when mem_we=1, mem[mem_address] SHALL take mem_data_w at the clock edge; the new value appears on mem_data_r from the next cycle onward.
REQ-017 In LOAD, DUMP and RELEASE, mem_we SHALL be ignored.
REQ-018 The control FSM SHALL have the states RUN, LOAD, DUMP and RELEASE; an internal counter cnt SHALL be ADDR_W bits wide.
REQ-019 RUN SHALL go to LOAD when ld_start=1, clearing cnt; otherwise RUN SHALL go to DUMP when dump_start=1, clearing cnt; if both are asserted in the same cycle, LOAD wins.
REQ-020 ld_start and dump_start SHALL be ignored in every state except RUN.
REQ-021 In LOAD, ld_ready SHALL be 1; on ld_valid&ld_ready, ld_data SHALL be written to mem[cnt] and cnt incremented; acceptance with cnt=15 SHALL go to RELEASE, and cnt SHALL wrap to 0.
REQ-022 In DUMP, dp_valid SHALL be 1, dp_addr SHALL equal cnt and dp_data SHALL equal mem[cnt]; these SHALL stay stable while dp_ready=0.
REQ-023 In DUMP, on dp_valid&dp_ready, cnt SHALL increment; the beat with cnt=15 SHALL go to RELEASE.
REQ-024 RELEASE SHALL last exactly one cycle and then go to RUN.
REQ-025 cpu_reset_n SHALL go 0 at the edge entering LOAD or DUMP, stay 0 through RELEASE, and go 1 at the edge entering RUN.
REQ-026 ld_ready SHALL be 0 outside LOAD, and dp_valid SHALL be 0 outside DUMP.
REQ-027 An idle load or dump stream (ld_valid=0 or dp_ready=0) SHALL stall the FSM indefinitely, with no timeout.

Reset
REQ-028 On reset=1 at a clock edge, the FSM SHALL go to RUN with cnt=0, cpu_reset_n=1, ld_ready=0, dp_valid=0 and busy=0.
REQ-029 Reset SHALL NOT modify memory contents; bytes written before a reset that aborts a load SHALL remain.
REQ-030 Reset SHALL take priority over every other input, including ld_start and mem_we in the same cycle.

Structure
REQ-031 ADDR_W, DATA_W and the FSM state enumeration SHALL live in the shared package cpu_pkg.
REQ-032 Storage SHALL be a sub-module ram16x8 with one synchronous write port and two combinational read ports (CPU and dump); prog_mem SHALL hold the FSM, the counter and the write-port mux (CPU in RUN, loader in LOAD).

Verification
REQ-033 Load scenario: ld_start, then 16 bytes 0x80..0x8F with ld_valid held -> mem[i]=0x80+i; cpu_reset_n low from the cycle after ld_start through RELEASE, then high; busy mirrors it.
REQ-034 CPU write scenario: in RUN, mem_address=0xA, mem_data_w=0x07, mem_we=1 -> mem_data_r=0x07 next cycle at address 0xA; the same write during LOAD -> mem[0xA] unchanged.
REQ-035 Load backpressure scenario: ld_valid deasserted for 3 cycles before byte 5 -> exactly 16 writes in order, and no write in the stall cycles.
REQ-036 Dump scenario: dump_start with dp_ready low for 4 cycles at beat 3 -> dp_addr=3 and dp_data=mem[3] held stable; 16 beats with addresses 0..15; then RELEASE, then RUN.
REQ-037 Start arbitration scenario: ld_start and dump_start in the same cycle -> LOAD; ld_start during DUMP -> ignored, and the dump completes all 16 beats.
REQ-038 Reset-during-load scenario: reset after 7 accepted bytes -> RUN next cycle with cpu_reset_n=1; mem[0..6] hold the new bytes and mem[7..15] their old values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and control-state encoding for the program memory and its loader.
package cpu_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_DUMP,
    ST_RELEASE
  } state_t;
endpackage

// File: rtl/prog_mem_if.sv
// CPU bus, load stream and dump stream of the program memory, bundled as one interface.
interface prog_mem_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_r;
  logic [DATA_W-1:0] mem_data_w;
  logic              mem_we;
  logic              cpu_reset_n;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              dump_start;
  logic              dp_valid;
  logic [ADDR_W-1:0] dp_addr;
  logic [DATA_W-1:0] dp_data;
  logic              dp_ready;
  logic              busy;

  modport slave (
    input  mem_address, mem_data_w, mem_we, ld_start, ld_valid, ld_data,
           dump_start, dp_ready,
    output mem_data_r, cpu_reset_n, ld_ready, dp_valid, dp_addr, dp_data, busy
  );

  modport master (
    output mem_address, mem_data_w, mem_we, ld_start, ld_valid, ld_data,
           dump_start, dp_ready,
    input  mem_data_r, cpu_reset_n, ld_ready, dp_valid, dp_addr, dp_data, busy
  );
endinterface

// File: rtl/ram16x8.sv
// Word storage: one synchronous write port, two combinational read ports (CPU and dump).
module ram16x8 #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents survive reset on purpose: an aborted load keeps its partial image.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/prog_mem.sv
// Program memory with a byte-stream loader and a dump streamer; holds the CPU in
// reset (cpu_reset_n low) whenever the loader or dumper owns the memory.
module prog_mem #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic      clk,
  input  logic      reset,
  prog_mem_if.slave bus
);
  import cpu_pkg::*;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_next;
  logic              r_cpu_reset_n;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_cpu_rdata;
  logic [DATA_W-1:0] w_dump_rdata;
  logic              w_ld_fire;
  logic              w_dp_fire;
  logic              w_last;

  assign w_last    = (r_cnt == {ADDR_W{1'b1}});
  assign w_ld_fire = (r_state == ST_LOAD) && bus.ld_valid;
  assign w_dp_fire = (r_state == ST_DUMP) && bus.dp_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (bus.ld_start) begin
          w_state_next = ST_LOAD;
          w_cnt_next   = '0;
        end else if (bus.dump_start) begin
          w_state_next = ST_DUMP;
          w_cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        if (w_ld_fire) begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_last) w_state_next = ST_RELEASE;
        end
      end
      ST_DUMP: begin
        if (w_dp_fire) begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_last) w_state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: w_state_next = ST_RUN;
      default:    w_state_next = ST_RUN;
    endcase
  end

  // cpu_reset_n follows the state being entered, so it drops on the edge into
  // LOAD/DUMP and rises on the edge back into RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_cnt         <= '0;
      r_cpu_reset_n <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_cpu_reset_n <= (w_state_next == ST_RUN);
    end
  end

  // Write-port owner: CPU in RUN, loader in LOAD, nobody otherwise or under reset.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.mem_address;
    w_wdata = bus.mem_data_w;
    if (!reset) begin
      if (r_state == ST_RUN) begin
        w_we = bus.mem_we;
      end else if (w_ld_fire) begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = bus.ld_data;
      end
    end
  end

  ram16x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (bus.mem_address),
    .o_rdata_a (w_cpu_rdata),
    .i_raddr_b (r_cnt),
    .o_rdata_b (w_dump_rdata)
  );

  assign bus.mem_data_r  = w_cpu_rdata;
  assign bus.cpu_reset_n = r_cpu_reset_n;
  assign bus.busy        = (r_state != ST_RUN);
  assign bus.ld_ready    = (r_state == ST_LOAD);
  assign bus.dp_valid    = (r_state == ST_DUMP);
  assign bus.dp_addr     = r_cnt;
  assign bus.dp_data     = w_dump_rdata;
endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: CPU write table, load/dump sequences with
// backpressure, start arbitration, reset aborts and randomized rounds against an array model.
module tb_prog_mem;
  logic clk;
  logic reset;

  prog_mem_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  prog_mem #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [16];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       we;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_address = '0;
    bus.mem_data_w  = '0;
    bus.mem_we      = 1'b0;
    bus.ld_start    = 1'b0;
    bus.ld_valid    = 1'b0;
    bus.ld_data     = '0;
    bus.dump_start  = 1'b0;
    bus.dp_ready    = 1'b0;
  endtask

  task automatic check_mem(input string name);
    for (int a = 0; a < 16; a++) begin
      bus.mem_address = 4'(a);
      #1;
      chk(name, bus.mem_data_r, model[a]);
    end
    bus.mem_address = '0;
  endtask

  task automatic cpu_random_ops(input int n);
    logic [3:0] a;
    logic [7:0] d;
    logic       we;
    for (int i = 0; i < n; i++) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      we = 1'($urandom_range(0, 1));
      bus.mem_address = a;
      bus.mem_data_w  = d;
      bus.mem_we      = we;
      #1;
      chk("rand_cpu_pre_edge", bus.mem_data_r, model[a]);
      tick();
      bus.mem_we = 1'b0;
      if (we) model[a] = d;
      chk("rand_cpu_read", bus.mem_data_r, model[a]);
    end
  endtask

  // Starts a load and streams 16 bytes; optionally stalls, randomizes valid,
  // raises dump_start alongside ld_start, or attempts a CPU write while loading.
  task automatic load_seq(input logic [7:0] base, input int stall_byte, input int stall_len,
                          input bit rand_valid, input bit both_starts, input bit cpu_poke);
    int acc = 0;
    int stalled = 0;
    bit v;
    bus.ld_start   = 1'b1;
    bus.dump_start = both_starts;
    tick();
    bus.ld_start   = 1'b0;
    bus.dump_start = 1'b0;
    chk("load_entry_ld_ready", bus.ld_ready, 1);
    chk("load_entry_dp_valid", bus.dp_valid, 0);
    chk("load_entry_cpu_reset_n", bus.cpu_reset_n, 0);
    if (cpu_poke) begin
      bus.mem_address = 4'hA;
      bus.mem_data_w  = 8'h5A;
      bus.mem_we      = 1'b1;
      bus.ld_valid    = 1'b0;
      tick();
      bus.mem_we = 1'b0;
      chk("cpu_write_ignored_in_load", bus.mem_data_r, model[10]);
    end
    for (int cyc = 0; cyc < 400 && acc < 16; cyc++) begin
      if (rand_valid) begin
        v = 1'($urandom_range(0, 1));
      end else begin
        v = !(acc == stall_byte && stalled < stall_len);
        if (!v) stalled++;
      end
      bus.ld_valid   = v;
      bus.ld_data    = v ? (rand_valid ? 8'($urandom_range(0, 255)) : base + 8'(acc)) : 8'hEE;
      bus.dump_start = rand_valid ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("load_ld_ready", bus.ld_ready, 1);
      chk("load_cpu_reset_n", bus.cpu_reset_n, 0);
      if (v) begin
        model[acc] = bus.ld_data;
        acc++;
      end
      tick();
    end
    bus.ld_valid   = 1'b0;
    bus.dump_start = 1'b0;
    chk("load_byte_count", acc, 16);
    chk("release_ld_ready", bus.ld_ready, 0);
    chk("release_busy", bus.busy, 1);
    chk("release_cpu_reset_n", bus.cpu_reset_n, 0);
    tick();
    chk("run_after_load_cpu_reset_n", bus.cpu_reset_n, 1);
    chk("run_after_load_busy", bus.busy, 0);
    $display("load base=%02h stall_byte=%0d stall_len=%0d rand=%0d done", base, stall_byte,
             stall_len, rand_valid);
  endtask

  // Starts a dump and consumes 16 beats; optionally stalls one beat, randomizes
  // ready, or raises ld_start while the dump is running.
  task automatic dump_seq(input int stall_beat, input int stall_len, input bit rand_ready,
                          input bit poke_ld);
    int b = 0;
    int stalled = 0;
    bit r;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    chk("dump_entry_cpu_reset_n", bus.cpu_reset_n, 0);
    for (int cyc = 0; cyc < 400 && b < 16; cyc++) begin
      if (rand_ready) begin
        r = 1'($urandom_range(0, 1));
      end else begin
        r = !(b == stall_beat && stalled < stall_len);
        if (!r) stalled++;
      end
      bus.dp_ready = r;
      bus.ld_start = poke_ld ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("dump_dp_valid", bus.dp_valid, 1);
      chk("dump_dp_addr", bus.dp_addr, b);
      chk("dump_dp_data", bus.dp_data, model[b]);
      chk("dump_ld_ready", bus.ld_ready, 0);
      if (r) b++;
      tick();
    end
    bus.dp_ready = 1'b0;
    bus.ld_start = 1'b0;
    chk("dump_beat_count", b, 16);
    chk("dump_release_dp_valid", bus.dp_valid, 0);
    chk("dump_release_busy", bus.busy, 1);
    chk("dump_release_cpu_reset_n", bus.cpu_reset_n, 0);
    tick();
    chk("run_after_dump_cpu_reset_n", bus.cpu_reset_n, 1);
    chk("run_after_dump_busy", bus.busy, 0);
    $display("dump stall_beat=%0d stall_len=%0d rand=%0d ld_poke=%0d done", stall_beat,
             stall_len, rand_ready, poke_ld);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    vt[0] = '{addr: 4'hA, data: 8'h07, we: 1'b1, exp: 8'h07};
    vt[1] = '{addr: 4'h3, data: 8'h55, we: 1'b0, exp: 8'h83};
    vt[2] = '{addr: 4'h0, data: 8'hFF, we: 1'b1, exp: 8'hFF};
    vt[3] = '{addr: 4'hF, data: 8'h11, we: 1'b1, exp: 8'h11};
    vt[4] = '{addr: 4'hA, data: 8'h99, we: 1'b0, exp: 8'h07};
    vt[5] = '{addr: 4'h5, data: 8'h00, we: 1'b1, exp: 8'h00};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_cpu_reset_n", bus.cpu_reset_n, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_ld_ready", bus.ld_ready, 0);
    chk("reset_dp_valid", bus.dp_valid, 0);
    $display("reset released");

    load_seq(8'h80, 16, 0, 1'b0, 1'b0, 1'b0);
    check_mem("load_0x80_contents");

    for (int i = 0; i < 6; i++) begin
      bus.mem_address = vt[i].addr;
      bus.mem_data_w  = vt[i].data;
      bus.mem_we      = vt[i].we;
      #1;
      chk("cpu_pre_edge_read", bus.mem_data_r, model[vt[i].addr]);
      tick();
      bus.mem_we = 1'b0;
      chk("cpu_table_read", bus.mem_data_r, vt[i].exp);
      if (vt[i].we) model[vt[i].addr] = vt[i].data;
      $display("cpu vec %0d addr=%h data=%02h we=%0d read=%02h", i, vt[i].addr, vt[i].data,
               vt[i].we, bus.mem_data_r);
    end

    load_seq(8'h20, 5, 3, 1'b0, 1'b0, 1'b1);
    check_mem("load_backpressure_contents");

    dump_seq(3, 4, 1'b0, 1'b0);

    load_seq(8'h40, 16, 0, 1'b0, 1'b1, 1'b0);
    check_mem("load_arbitration_contents");

    dump_seq(16, 0, 1'b0, 1'b1);

    // Reset in RUN outranks a CPU write and a load request in the same cycle.
    bus.mem_address = 4'h2;
    bus.mem_data_w  = 8'h77;
    bus.mem_we      = 1'b1;
    bus.ld_start    = 1'b1;
    reset           = 1'b1;
    tick();
    idle_inputs();
    reset = 1'b0;
    chk("reset_prio_busy", bus.busy, 0);
    chk("reset_prio_ld_ready", bus.ld_ready, 0);
    bus.mem_address = 4'h2;
    #1;
    chk("reset_prio_mem2", bus.mem_data_r, model[2]);
    $display("reset priority over mem_we/ld_start checked");

    // Reset after 7 accepted bytes aborts the load but keeps what was written.
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'hC0 + 8'(i);
      model[i]     = bus.ld_data;
      tick();
    end
    bus.ld_data = 8'hEE;
    reset       = 1'b1;
    tick();
    idle_inputs();
    reset = 1'b0;
    chk("abort_cpu_reset_n", bus.cpu_reset_n, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ld_ready", bus.ld_ready, 0);
    chk("abort_dp_valid", bus.dp_valid, 0);
    check_mem("abort_contents");
    $display("reset during load after 7 bytes checked");

    for (int round = 0; round < 3; round++) begin
      cpu_random_ops(20);
      load_seq(8'h00, 16, 0, 1'b1, 1'b0, 1'b0);
      check_mem("rand_load_contents");
      dump_seq(16, 0, 1'b1, 1'b1);
      $display("random round %0d done", round);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
